// File: rtl/icache_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped instruction cache sitting between the fetch stage and a simple
// word-at-a-time backing memory.  Lookups are zero-latency: a hit returns the
// instruction in the same cycle the address is presented.  A miss stalls the
// program counter and refills the whole line one beat at a time, after which
// the held address hits.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : asynchronous, active-low reset
//   addr       : fetch address (program counter)
//   instr      : instruction word for addr (NOP while stalled)
//   pc_stall   : high when instr is not valid; fetch holds the PC
//   flush      : invalidate every line (fence.i)
//   mem_req    : refill beat request to backing memory
//   mem_addr   : word-aligned refill beat address
//   mem_ready  : beat accepted, mem_rdata valid this cycle
//   mem_rdata  : refill data word
// -----------------------------------------------------------------------------
module icache_responder #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   output logic [31:0] instr,
   output logic        pc_stall,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int LA_W  = 30 - OFF_W;
   localparam int TAG_W = LA_W - IDX_W;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   state_t                r_state;
   logic [OFF_W-1:0]      r_beat;
   logic [LA_W-1:0]       r_lineAddr;
   logic                  r_flushPending;
   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [31:0]           r_data [LINES][WORDS];

   logic [OFF_W-1:0]      w_offset;
   logic [IDX_W-1:0]      w_index;
   logic [TAG_W-1:0]      w_tag;
   logic [IDX_W-1:0]      w_refillIdx;
   logic                  w_hit;
   logic                  w_lastBeat;
   logic                  w_unusedByteBits;

   // Address decomposition: byte bits are dropped, then offset, index and tag
   // from low to high.  The line being refilled is identified purely by the
   // latched line address so that addr may wander during the refill.
   assign w_offset         = addr[OFF_W+1:2];
   assign w_index          = addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_tag            = addr[31:OFF_W+IDX_W+2];
   assign w_refillIdx      = r_lineAddr[IDX_W-1:0];
   assign w_lastBeat       = (r_beat == OFF_W'(WORDS - 1));
   assign w_unusedByteBits = ^addr[1:0];

   // A flush in the same cycle always reports a miss, even when the tag
   // would match, because the line is being invalidated at this edge.
   assign w_hit = (r_state == IDLE) && r_valid[w_index] &&
                  (r_tag[w_index] == w_tag) && !flush;

   // Output decode.  Hits are served straight from the arrays in the same
   // cycle; anything else stalls with a NOP.  The memory request is simply
   // the refill state, so an asynchronous reset drops it immediately.
   always_comb begin
      instr    = NOP;
      pc_stall = 1'b1;
      mem_req  = 1'b0;
      mem_addr = 32'h0;
      if (w_hit) begin
         instr    = r_data[w_index][w_offset];
         pc_stall = 1'b0;
      end
      if (r_state == REFILL) begin
         mem_req  = 1'b1;
         mem_addr = {r_lineAddr, r_beat, 2'b00};
      end
   end

   // Control FSM and valid bits.  A flush clears every valid bit at the edge
   // it is seen.  If it lands during a refill the refill still drains all of
   // its beats (the memory side expects that), but the pending flag keeps the
   // freshly filled line invalid so the next lookup misses again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_beat         <= '0;
         r_lineAddr     <= '0;
         r_flushPending <= 1'b0;
         r_valid        <= '0;
      end else begin
         if (flush) begin
            r_valid <= '0;
         end
         case (r_state)
            IDLE: begin
               if (!w_hit) begin
                  r_lineAddr     <= addr[31:OFF_W+2];
                  r_beat         <= '0;
                  r_flushPending <= 1'b0;
                  r_state        <= REFILL;
               end
            end
            REFILL: begin
               if (flush) begin
                  r_flushPending <= 1'b1;
               end
               if (mem_ready) begin
                  r_beat <= r_beat + 1'b1;
                  if (w_lastBeat) begin
                     r_state <= IDLE;
                     if (!flush && !r_flushPending) begin
                        r_valid[w_refillIdx] <= 1'b1;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Tag and data storage.  These arrays carry no reset; a line's contents
   // only matter once its valid bit is set, and reset clears those.  The tag
   // is written with the final beat, together with the valid bit above.
   always_ff @(posedge clk) begin
      if (r_state == REFILL && mem_ready) begin
         r_data[w_refillIdx][r_beat] <= mem_rdata;
         if (w_lastBeat) begin
            r_tag[w_refillIdx] <= r_lineAddr[LA_W-1:IDX_W];
         end
      end
   end

endmodule

// File: tb/tb_icache_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_icache_responder
//
// Directed bench for the instruction cache.  Backing memory returns
// 0xA0 + (address - 0x100)/4, so line 0x100 holds A0..A3 and line 0x200 holds
// E0..E3.  Each fetch pushes its expected instruction and its expected refill
// beat addresses into queues; a monitor pops them whenever the cache delivers
// an instruction or accepts a beat.
// -----------------------------------------------------------------------------
module tb_icache_responder;

   localparam int WORDS = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } hit_t;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] instr;
   logic        pc_stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   hit_t        sbQ[$];
   logic [31:0] beatQ[$];
   int          total;
   int          bad;

   icache_responder #(.LINES(16), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .instr     (instr),
      .pc_stall  (pc_stall),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory answers combinationally from the requested address.
   always_comb begin
      mem_rdata = 32'hA0 + ((mem_addr - 32'h100) >> 2);
   end

   // Single comparison point shared by stimulus and monitor.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every delivered instruction and every accepted beat must match
   // the head of its queue.
   always @(negedge clk) begin
      if (rst) begin
         if (!pc_stall) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpectedHit", addr, 32'hFFFF_FFFF);
            end else begin
               hit_t e;
               e = sbQ.pop_front();
               checkOutput("hitAddr", addr, e.a);
               checkOutput("hitInstr", instr, e.d);
            end
         end
         if (mem_req && mem_ready) begin
            if (beatQ.size() == 0) begin
               checkOutput("unexpectedBeat", mem_addr, 32'hFFFF_FFFF);
            end else begin
               checkOutput("beatOrder", mem_addr, beatQ.pop_front());
            end
         end
      end
   end

   // One fetch: hold addr until the cache delivers, with an optional
   // mem_ready pattern (LSB first, starting at the first refill cycle) and an
   // optional one-cycle flush pulse.  Entered and left at posedge + 1.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] expData,
                                input int expCycles, input int nRefills,
                                input logic [15:0] pat, input int patLen,
                                input int flushCycle);
      int          cyc;
      int          accepted;
      bit          done;
      logic [31:0] base;
      hit_t        e;
      base = a & ~32'hF;
      e.a  = a;
      e.d  = expData;
      sbQ.push_back(e);
      for (int r = 0; r < nRefills; r++) begin
         for (int w = 0; w < WORDS; w++) begin
            beatQ.push_back(base + 32'(4 * w));
         end
      end
      cyc      = 0;
      accepted = 0;
      done     = 1'b0;
      while (!done) begin
         cyc++;
         addr      = a;
         flush     = (cyc == flushCycle);
         mem_ready = (cyc >= 2 && (cyc - 2) < patLen) ? pat[cyc-2] : 1'b1;
         @(negedge clk);
         if (!pc_stall) begin
            done = 1'b1;
         end else begin
            if (mem_req) begin
               checkOutput("beatAddr", mem_addr, base + 32'(4 * (accepted % WORDS)));
               if (mem_ready) accepted++;
            end
            if (cyc > 40) begin
               checkOutput("fetchTimeout", 32'(cyc), 32'(expCycles));
               done = 1'b1;
            end
         end
         if (!done) begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput("latency", 32'(cyc), 32'(expCycles));
      checkOutput("hitMemReq", {31'b0, mem_req}, 32'h0);
      checkOutput("hitMemAddr", mem_addr, 32'h0);
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b0;
      addr      = 32'h100;
      flush     = 1'b0;
      mem_ready = 1'b0;

      // Reset state with an address presented.
      #3;
      checkOutput("rstStall", {31'b0, pc_stall}, 32'h1);
      checkOutput("rstInstr", instr, NOP);
      checkOutput("rstMemReq", {31'b0, mem_req}, 32'h0);
      checkOutput("rstMemAddr", mem_addr, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Cold miss, then hits across the line.
      applyStimulus(32'h100, 32'hA0, 6, 1, 16'h0, 0, 0);
      applyStimulus(32'h104, 32'hA1, 1, 0, 16'h0, 0, 0);
      applyStimulus(32'h108, 32'hA2, 1, 0, 16'h0, 0, 0);
      applyStimulus(32'h10C, 32'hA3, 1, 0, 16'h0, 0, 0);

      // Conflict eviction in index 0 and back again.
      applyStimulus(32'h200, 32'hE0, 6, 1, 16'h0, 0, 0);
      applyStimulus(32'h100, 32'hA0, 6, 1, 16'h0, 0, 0);

      // Backpressure 1,0,0,1,1,0,1.
      applyStimulus(32'h204, 32'hE1, 9, 1, 16'h0059, 7, 0);
      applyStimulus(32'h208, 32'hE2, 1, 0, 16'h0, 0, 0);

      // Flush during beat 2: refill drains, line stays invalid, refills again.
      applyStimulus(32'h100, 32'hA0, 11, 2, 16'h0, 0, 4);

      // Flush in idle forces a miss on a resident line.
      applyStimulus(32'h104, 32'hA1, 6, 1, 16'h0, 0, 1);
      applyStimulus(32'h10C, 32'hA3, 1, 0, 16'h0, 0, 0);

      // Reset during beat 1 of a refill of line 0x210.
      addr      = 32'h210;
      mem_ready = 1'b1;
      beatQ.push_back(32'h210);
      @(posedge clk);
      #1;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("midRstMemReq", {31'b0, mem_req}, 32'h0);
      checkOutput("midRstMemAddr", mem_addr, 32'h0);
      checkOutput("midRstStall", {31'b0, pc_stall}, 32'h1);
      checkOutput("midRstInstr", instr, NOP);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(32'h100, 32'hA0, 6, 1, 16'h0, 0, 0);
      applyStimulus(32'h210, 32'hE4, 6, 1, 16'h0, 0, 0);

      checkOutput("sbDrained", 32'(sbQ.size()), 32'h0);
      checkOutput("beatDrained", 32'(beatQ.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
- REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two, >=2).
- REQ-002 SHALL have parameter WORDS, default 4, 32-bit words per line (power of two, >=2).
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
- REQ-005 SHALL have port addr  input  32  fetch address (program counter) from fetch stage.
- REQ-006 SHALL have port instr  output  32  instruction word for addr.
- REQ-007 SHALL have port pc_stall  output  1  high = instr not valid; fetch holds program counter.
- REQ-008 SHALL have port flush  input  1  invalidate all lines (fence.i).
- REQ-009 SHALL have port mem_req  output  1  refill beat request to backing memory.
- REQ-010 SHALL have port mem_addr  output  32  word-aligned refill beat address.
- REQ-011 SHALL have port mem_ready  input  1  beat accepted; mem_rdata valid this cycle.
- REQ-012 SHALL have port mem_rdata  input  32  refill data word.

Function
- REQ-013 SHALL split addr as: bits[1:0] ignored; offset = next log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining upper bits.
- REQ-014 SHALL store per line: valid bit, tag, WORDS data words.
- REQ-015 SHALL implement FSM states IDLE and REFILL; reset state IDLE.
- REQ-016 SHALL, in IDLE, compute hit combinationally = valid[index] & (tag match).
- REQ-017 SHALL, on hit in IDLE, drive instr = stored word[offset] and pc_stall = 0 in the same cycle (zero-latency lookup).
- REQ-018 SHALL, on miss in IDLE, drive pc_stall = 1, instr = 32'h00000013 (NOP), latch the line base address (addr with offset and byte bits zeroed), clear beat counter, and enter REFILL next edge.
- REQ-019 SHALL, in REFILL, drive pc_stall = 1, instr = 32'h00000013, mem_req = 1, mem_addr = line base + 4*beat.
- REQ-020 SHALL, on each REFILL cycle with mem_ready = 1, write mem_rdata into word[beat] of the latched index and increment beat; with mem_ready = 0, hold beat and mem_addr.
- REQ-021 SHALL, on the beat WORDS-1 handshake, write tag, set valid (unless REQ-024 applies), return to IDLE; the held address hits in the following cycle.
- REQ-022 SHALL use the latched line base throughout REFILL, ignoring addr changes.
- REQ-023 SHALL drive mem_req = 0 and mem_addr = 0 in IDLE.
- REQ-024 SHALL, on flush = 1, clear all valid bits at that edge; flush during REFILL lets the refill complete (all beats consumed) but the line is left invalid, forcing a new miss.
- REQ-025 SHALL, when flush = 1 in IDLE, report miss (pc_stall = 1) that cycle regardless of tag match.
- REQ-026 SHALL require miss-to-hit latency of exactly WORDS + 2 cycles with mem_ready held high (1 miss-detect cycle, WORDS beats, 1 hit cycle).

Reset
- REQ-027 SHALL, while rst = 0, immediately force state IDLE, beat = 0, all valid bits 0, mem_req = 0, mem_addr = 0, pc_stall = 1 if addr presented, instr = 32'h00000013.
- REQ-028 SHALL, on reset assertion mid-REFILL, abandon the refill with no line marked valid; tag/data contents are don't-care.
- REQ-029 SHALL leave tag and data arrays unreset; only valid bits are reset.

Verification
- REQ-030 SHALL cover cold miss: after reset, addr=0x100, mem_ready=1, memory returns 0xA0,0xA1,0xA2,0xA3 -> mem_addr 0x100,0x104,0x108,0x10C; pc_stall low on cycle 6; instr=0xA0.
- REQ-031 SHALL cover hit sweep: after REQ-030, addr=0x104/0x108/0x10C -> instr=0xA1/0xA2/0xA3, pc_stall=0, mem_req=0.
- REQ-032 SHALL cover conflict eviction: addr=0x100 then 0x200 (defaults, same index 0) -> refill of 0x200; return to 0x100 misses again.
- REQ-033 SHALL cover backpressure: mem_ready toggles 1,0,0,1,1,0,1 -> mem_addr holds on 0-cycles; words written in order; hit after 4th accepted beat.
- REQ-034 SHALL cover flush mid-refill: flush pulsed during beat 2 -> refill completes, next lookup of same addr misses and refills again.
- REQ-035 SHALL cover reset mid-refill: rst=0 during beat 1 -> mem_req drops asynchronously; after release addr=0x100 misses and refills from beat 0.
